// File: rtl/reload_timer.sv
// reload_timer
//   Down-counting beat timer with a held period register. Counts qualified
//   count_en beats from the programmed period and emits a one-cycle out pulse
//   when the final beat is consumed. Supports one-shot and auto-reload modes,
//   explicit start/stop, a live count readout and a sticky done flag.
//
// Ports
//   clock       : single clock, all state updates on the rising edge
//   reset       : synchronous, active-high; clears all state
//   count_en    : beat qualifier, the counter only decrements on these cycles
//   load        : capture load_value into the period register
//   load_value  : new period in beats
//   start       : begin counting from the period (restarts if already running)
//   stop        : halt counting, count is held
//   auto_reload : 1 = periodic, 0 = one-shot
//   out         : registered expiry pulse
//   running     : high while counting
//   done        : sticky one-shot completion flag
//   count       : current counter value
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | not counting; load writes both period and count
// RUN   | decrementing on count_en beats; load only updates the period

module reload_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             count_en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic             out,
  output logic             running,
  output logic             done,
  output logic [WIDTH-1:0] count
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] period_next;
  logic [WIDTH-1:0] count_next;
  logic             out_next;
  logic             done_next;

  logic [WIDTH-1:0] eff_period;
  logic             start_ok;
  logic             expiry;

  // A start in the same cycle as a load counts from the value being loaded.
  assign eff_period = load ? load_value : period;
  assign start_ok   = start && (eff_period != '0);
  assign expiry     = (state == RUN) && count_en && (count == WIDTH'(1));

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      period <= '0;
      count  <= '0;
      out    <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      period <= period_next;
      count  <= count_next;
      out    <= out_next;
      done   <= done_next;
    end
  end

  // Next-state logic: stop > start > expiry beat; load is independent.
  always_comb begin
    state_next  = state;
    period_next = load ? load_value : period;
    count_next  = count;
    out_next    = 1'b0;
    done_next   = done;

    // In RUN the count in progress is left alone; the new period waits for
    // the next reload or start.
    if (state == IDLE && load) begin
      count_next = load_value;
    end

    if (stop) begin
      state_next = IDLE;
    end else if (start_ok) begin
      state_next = RUN;
      count_next = eff_period;
      done_next  = 1'b0;
    end else if (expiry) begin
      out_next = 1'b1;
      if (auto_reload) begin
        // Reload from the register as it stands before this edge's load.
        count_next = period;
      end else begin
        count_next = '0;
        state_next = IDLE;
        done_next  = 1'b1;
      end
    end else if (state == RUN && count_en && count > WIDTH'(1)) begin
      count_next = count - WIDTH'(1);
    end
  end

  // Output decode
  always_comb begin
    running = (state == RUN);
  end

endmodule

// File: tb/tb_reload_timer.sv
// Bench for reload_timer: directed vector table, two multi-cycle periodic
// sequences, then randomized traffic against a behavioural model.

module tb_reload_timer;

  logic       clock;
  logic       reset;
  logic       count_en;
  logic       load;
  logic [7:0] load_value;
  logic       start;
  logic       stop;
  logic       auto_reload;
  logic       out;
  logic       running;
  logic       done;
  logic [7:0] count;

  int checks = 0;
  int errors = 0;

  reload_timer #(.WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .count_en   (count_en),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .stop       (stop),
    .auto_reload(auto_reload),
    .out        (out),
    .running    (running),
    .done       (done),
    .count      (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       en;
    logic       ld;
    logic [7:0] lv;
    logic       st;
    logic       sp;
    logic       ar;
    logic [7:0] e_count;
    logic       e_run;
    logic       e_out;
    logic       e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic rst, logic en, logic ld, logic [7:0] lv,
                              logic st, logic sp, logic ar, logic [7:0] ec,
                              logic er, logic eo, logic ed);
    vec_t v;
    v.rst = rst; v.en = en; v.ld = ld; v.lv = lv; v.st = st; v.sp = sp;
    v.ar = ar; v.e_count = ec; v.e_run = er; v.e_out = eo; v.e_done = ed;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic rst, logic en, logic ld, logic [7:0] lv,
                       logic st, logic sp, logic ar);
    reset = rst; count_en = en; load = ld; load_value = lv;
    start = st; stop = sp; auto_reload = ar;
  endtask

  // Apply current inputs for one edge; outputs are sampled 1 time unit later.
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(string tag, logic [7:0] ec, logic er, logic eo, logic ed);
    check({tag, ".count"},   32'(count),   32'(ec));
    check({tag, ".running"}, 32'(running), 32'(er));
    check({tag, ".out"},     32'(out),     32'(eo));
    check({tag, ".done"},    32'(done),    32'(ed));
  endtask

  // Behavioural model state
  bit m_run;
  int m_period;
  int m_count;
  bit m_out;
  bit m_done;

  function automatic void model_step(bit rst, bit en, bit ld, int lv,
                                     bit st, bit sp, bit ar);
    int  eff;
    bit  fire;
    int  n_count;
    bit  n_run;
    bit  n_done;
    bit  n_out;
    if (rst) begin
      m_run = 0; m_period = 0; m_count = 0; m_out = 0; m_done = 0;
      return;
    end
    eff     = ld ? lv : m_period;
    fire    = m_run && en && (m_count == 1);
    n_count = m_count;
    n_run   = m_run;
    n_done  = m_done;
    n_out   = 0;
    if (!m_run && ld) n_count = lv;
    if (sp) begin
      n_run = 0;
    end else if (st && eff != 0) begin
      n_run = 1; n_count = eff; n_done = 0;
    end else if (fire) begin
      n_out = 1;
      if (ar) n_count = m_period;
      else begin
        n_count = 0; n_run = 0; n_done = 1;
      end
    end else if (m_run && en && m_count > 1) begin
      n_count = m_count - 1;
    end
    m_period = eff;
    m_count  = n_count;
    m_run    = n_run;
    m_done   = n_done;
    m_out    = n_out;
  endfunction

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);

    //   rst en ld lv st sp ar | count run out done
    add(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);  // reset
    add(0, 0, 1, 4, 0, 0, 0,   4, 0, 0, 0);  // load 4 in IDLE shows on count
    add(0, 0, 0, 0, 1, 0, 0,   4, 1, 0, 0);  // start
    add(0, 1, 0, 0, 0, 0, 0,   3, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0,   2, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0,   1, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0,   0, 0, 1, 1);  // one-shot expiry
    add(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1);  // IDLE ignores beats, done sticky
    add(0, 0, 1, 6, 1, 0, 0,   6, 1, 0, 0);  // start with load 6
    add(0, 1, 0, 0, 0, 0, 0,   5, 1, 0, 0);
    add(0, 1, 0, 0, 1, 1, 0,   5, 0, 0, 0);  // stop beats start, count holds
    add(0, 0, 1, 0, 1, 0, 0,   0, 0, 0, 0);  // start with load 0 ignored
    add(0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0);  // start with period 0 ignored
    add(0, 0, 1, 3, 1, 0, 0,   3, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0);  // reset mid-count at 3
    add(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0);  // nothing moves afterwards
    add(0, 0, 1, 2, 1, 0, 0,   2, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0,   1, 1, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0,   1, 0, 0, 0);  // stop on expiry beat: no pulse
    add(0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0);
    add(0, 0, 1, 1, 1, 0, 1,   1, 1, 0, 0);  // period 1 periodic
    add(0, 1, 0, 0, 0, 0, 1,   1, 1, 1, 0);
    add(0, 1, 0, 0, 0, 0, 1,   1, 1, 1, 0);
    add(0, 1, 0, 0, 0, 0, 1,   1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,   1, 1, 0, 0);
    add(0, 0, 1, 9, 0, 0, 1,   1, 1, 0, 0);  // load in RUN leaves count alone

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].ld, vecs[i].lv,
            vecs[i].st, vecs[i].sp, vecs[i].ar);
      cycle();
      check_all($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_run,
                vecs[i].e_out, vecs[i].e_done);
    end

    // Periodic, period 3, ten beats two cycles apart.
    begin
      int pulses;
      pulses = 0;
      drive(1, 0, 0, 0, 0, 0, 1); cycle();
      drive(0, 0, 1, 3, 1, 0, 1); cycle();
      check("per3.start_count", 32'(count), 32'd3);
      for (int b = 1; b <= 10; b++) begin
        drive(0, 1, 0, 0, 0, 0, 1); cycle();
        if (out) pulses++;
        check($sformatf("per3.beat%0d.out", b), 32'(out), 32'((b % 3) == 0));
        check($sformatf("per3.beat%0d.count", b), 32'(count),
              32'(((b % 3) == 0) ? 3 : 3 - (b % 3)));
        drive(0, 0, 0, 0, 0, 0, 1); cycle();
        check($sformatf("per3.gap%0d.out", b), 32'(out), 32'd0);
      end
      check("per3.pulses", 32'(pulses), 32'd3);
    end

    // Mid-run reprogramming: period 5, load 2 after beat 1.
    begin
      int exp_cnt[7] = '{4, 3, 2, 1, 2, 1, 2};
      drive(1, 0, 0, 0, 0, 0, 1); cycle();
      drive(0, 0, 1, 5, 1, 0, 1); cycle();
      drive(0, 1, 0, 0, 0, 0, 1); cycle();
      check("reprog.beat1.count", 32'(count), 32'(exp_cnt[0]));
      drive(0, 0, 1, 2, 0, 0, 1); cycle();
      check("reprog.load.count", 32'(count), 32'd4);
      for (int b = 2; b <= 7; b++) begin
        drive(0, 1, 0, 0, 0, 0, 1); cycle();
        check($sformatf("reprog.beat%0d.out", b), 32'(out), 32'(b == 5 || b == 7));
        check($sformatf("reprog.beat%0d.count", b), 32'(count), 32'(exp_cnt[b-1]));
      end
    end

    // Randomized traffic against the model.
    drive(1, 0, 0, 0, 0, 0, 0); cycle();
    model_step(1, 0, 0, 0, 0, 0, 0);
    begin
      bit ar_r;
      ar_r = 0;
      for (int n = 0; n < 3000; n++) begin
        bit r_rst, r_en, r_ld, r_st, r_sp;
        int r_lv;
        r_rst = ($urandom_range(0, 99) == 0);
        r_en  = $urandom_range(0, 1);
        r_ld  = ($urandom_range(0, 5) == 0);
        r_lv  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 5);
        r_st  = ($urandom_range(0, 7) == 0);
        r_sp  = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 19) == 0) ar_r = ~ar_r;
        drive(r_rst, r_en, r_ld, 8'(r_lv), r_st, r_sp, ar_r);
        model_step(r_rst, r_en, r_ld, r_lv, r_st, r_sp, ar_r);
        cycle();
        check_all($sformatf("rand%0d", n), 8'(m_count), m_run, m_out, m_done);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
